// File: rtl/pr_queue_axi_reader_pkg.sv
// Shared constants and types for the PR queue reader: read-word layout, queue
// slave addresses, AXI response codes and the reader's FSM encoding.
package pr_queue_axi_reader_pkg;

  localparam int unsigned OU_ID_W            = 4;
  localparam int unsigned GRID_SLOT_W        = 4;
  localparam int unsigned REQ_W              = OU_ID_W + GRID_SLOT_W;
  localparam int unsigned AXI_ADDR_W         = 2;
  localparam int unsigned AXI_DATA_W         = 32;
  localparam int unsigned AXI_RESP_W         = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  localparam logic [AXI_ADDR_W-1:0] PEEK_ADDR     = 2'b01;
  localparam logic [AXI_ADDR_W-1:0] POP_ADDR      = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [OU_ID_W-1:0]     ou_id;
    logic [GRID_SLOT_W-1:0] grid_slot;
  } pr_request_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PEEK_AR = 3'd1,
    ST_PEEK_R  = 3'd2,
    ST_OFFER   = 3'd3,
    ST_POP_AR  = 3'd4,
    ST_POP_R   = 3'd5
  } state_t;

  // Read word is {zeros, ou_id, grid_slot}; only the low REQ_W bits carry data.
  function automatic pr_request_t unpack_req(input logic [REQ_W-1:0] bits);
    return pr_request_t'(bits);
  endfunction

endpackage

// File: rtl/pr_queue_axi_reader_if.sv
// AXI4-Lite read-only channel bundle between the reader (master) and the
// PR queue slave.
interface pr_queue_axi_reader_if;
  import pr_queue_axi_reader_pkg::*;

  logic [AXI_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_RESP_W-1:0] rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/pr_queue_axi_reader_axil_read_channel.sv
// Single outstanding AXI4-Lite read: start/addr launches AR, the R beat is
// reported combinationally via done_c. Owns the arready-wait timeout counter.
module axil_read_channel
  import pr_queue_axi_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] addr,
  pr_queue_axi_reader_if.master axi,
  output logic                  ar_done_c,
  output logic                  done_c,
  output logic [AXI_DATA_W-1:0] data_c,
  output logic [AXI_RESP_W-1:0] resp_c,
  output logic                  timeout_c
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             busy_c;

  assign busy_c    = axi.arvalid || axi.rready;
  assign ar_done_c = axi.arvalid && axi.arready;
  assign done_c    = axi.rvalid && axi.rready;
  assign data_c    = axi.rdata;
  assign resp_c    = axi.rresp;
  // One-shot event on the stall cycle that brings the counter to saturation.
  assign timeout_c = axi.arvalid && !axi.arready && (wait_cnt == CNT_MAX - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (start && !busy_c) begin
        axi.arvalid <= 1'b1;
        axi.araddr  <= addr;
      end
      if (ar_done_c) begin
        axi.arvalid <= 1'b0;
        axi.rready  <= 1'b1;
      end
      if (done_c) begin
        axi.rready <= 1'b0;
      end
      // arvalid without a handshake implies arready is low this cycle.
      if (ar_done_c) begin
        wait_cnt <= '0;
      end else if (axi.arvalid && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pr_queue_axi_reader.sv
// Drains the PR request queue: peek the oldest entry, offer it to the loader,
// then pop it and confirm the popped word matches what was offered.
module pr_queue_axi_reader
  import pr_queue_axi_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_aresetn,
  input  logic                   pr_request_pending,
  pr_queue_axi_reader_if.master  m_axi,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [OU_ID_W-1:0]     req_ou_id,
  output logic [GRID_SLOT_W-1:0] req_grid_slot,
  input  logic                   err_clear,
  output logic                   err_mismatch,
  output logic                   err_resp,
  output logic                   err_timeout
);

  state_t                state;
  pr_request_t           req_q;
  pr_request_t           shadow_q;

  logic                  start_c;
  logic [AXI_ADDR_W-1:0] start_addr_c;
  logic                  ar_done_c;
  logic                  r_done_c;
  logic [AXI_DATA_W-1:0] r_data_c;
  logic [AXI_RESP_W-1:0] r_resp_c;
  logic                  timeout_c;
  pr_request_t           beat_req_c;
  logic                  beat_err_c;
  logic                  resp_set_c;
  logic                  mismatch_set_c;
  logic                  unused_upper;

  axil_read_channel #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_chan (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .start     (start_c),
    .addr      (start_addr_c),
    .axi       (m_axi),
    .ar_done_c (ar_done_c),
    .done_c    (r_done_c),
    .data_c    (r_data_c),
    .resp_c    (r_resp_c),
    .timeout_c (timeout_c)
  );

  assign req_ou_id     = req_q.ou_id;
  assign req_grid_slot = req_q.grid_slot;
  assign unused_upper  = ^r_data_c[AXI_DATA_W-1:REQ_W];

  // Launch requests: peek from IDLE, pop on the loader handshake.
  always_comb begin
    start_c      = 1'b0;
    start_addr_c = PEEK_ADDR;
    if (state == ST_IDLE) begin
      start_c = pr_request_pending;
    end else if (state == ST_OFFER) begin
      start_c      = req_ready;
      start_addr_c = POP_ADDR;
    end
  end

  always_comb begin
    beat_req_c     = unpack_req(r_data_c[REQ_W-1:0]);
    beat_err_c     = (r_resp_c != AXI_RESP_OKAY);
    resp_set_c     = r_done_c && beat_err_c && (state == ST_PEEK_R || state == ST_POP_R);
    mismatch_set_c = r_done_c && (state == ST_POP_R) && (beat_req_c != shadow_q);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state        <= ST_IDLE;
      req_valid    <= 1'b0;
      req_q        <= '0;
      shadow_q     <= '0;
      err_mismatch <= 1'b0;
      err_resp     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      // Sticky flags: a set event in the same cycle overrides err_clear.
      err_mismatch <= mismatch_set_c | (err_mismatch & ~err_clear);
      err_resp     <= resp_set_c     | (err_resp     & ~err_clear);
      err_timeout  <= timeout_c      | (err_timeout  & ~err_clear);

      case (state)
        ST_IDLE: begin
          if (pr_request_pending) state <= ST_PEEK_AR;
        end
        ST_PEEK_AR: begin
          if (ar_done_c) state <= ST_PEEK_R;
        end
        ST_PEEK_R: begin
          if (r_done_c) begin
            req_q    <= beat_req_c;
            shadow_q <= beat_req_c;
            if (beat_err_c) begin
              state <= ST_IDLE;
            end else begin
              req_valid <= 1'b1;
              state     <= ST_OFFER;
            end
          end
        end
        ST_OFFER: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_POP_AR;
          end
        end
        ST_POP_AR: begin
          if (ar_done_c) state <= ST_POP_R;
        end
        ST_POP_R: begin
          if (r_done_c) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_queue_axi_reader.sv
// Bench for pr_queue_axi_reader: a behavioural queue slave plus directed and
// randomized scenarios checked against an entry-order reference model.
module tb_pr_queue_axi_reader;
  import pr_queue_axi_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pending;
  logic       req_ready;
  logic       err_clear;
  logic       req_valid;
  logic [3:0] req_ou_id;
  logic [3:0] req_grid_slot;
  logic       err_mismatch;
  logic       err_resp;
  logic       err_timeout;

  pr_queue_axi_reader_if m_axi ();

  pr_queue_axi_reader dut (
    .m_axi_aclk         (clk),
    .m_axi_aresetn      (rst_n),
    .pr_request_pending (pending),
    .m_axi              (m_axi),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_ou_id          (req_ou_id),
    .req_grid_slot      (req_grid_slot),
    .err_clear          (err_clear),
    .err_mismatch       (err_mismatch),
    .err_resp           (err_resp),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [1:0] ar_log[$];
  logic [7:0] offer_log[$];
  logic [7:0] exp_q[$];
  bit         s_rand = 0;
  bit         rr_rand = 0;
  bit         s_ar_block = 0;
  bit         s_pop_block = 0;
  bit         s_busy = 0;
  int         peek_err_cnt = 0;
  int         pop_ovr_cnt = 0;
  logic [7:0] pop_ovr = 8'h00;
  int         stab_viol = 0;

  // Queue slave and loader-port monitor; drives on negedge, samples on posedge.
  initial begin : slave
    logic [1:0] rd_addr;
    int         lat;
    bit         prev_hold;
    logic [7:0] prev_req;
    rd_addr = 2'b00; lat = 0; prev_hold = 0; prev_req = 8'h00;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = 32'h0;
    m_axi.rresp = 2'b00; pending = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        s_busy = 0;
        prev_hold = 0;
      end else begin
        if (m_axi.arvalid && m_axi.arready) begin
          s_busy = 1;
          rd_addr = m_axi.araddr;
          lat = s_rand ? int'($urandom_range(0, 3)) : 0;
          ar_log.push_back(m_axi.araddr);
        end
        if (m_axi.rvalid && m_axi.rready) begin
          s_busy = 0;
          if (rd_addr == PEEK_ADDR && peek_err_cnt > 0) peek_err_cnt--;
          if (rd_addr == POP_ADDR) begin
            if (pop_ovr_cnt > 0) pop_ovr_cnt--;
            if (q.size() > 0) void'(q.pop_front());
          end
        end
        if (req_valid && req_ready) offer_log.push_back({req_ou_id, req_grid_slot});
        if (prev_hold && (!req_valid || {req_ou_id, req_grid_slot} !== prev_req)) stab_viol++;
        prev_hold = req_valid && !req_ready;
        prev_req  = {req_ou_id, req_grid_slot};
      end
      @(negedge clk);
      pending = (q.size() != 0);
      m_axi.arready = !s_busy && !s_ar_block &&
                      !(s_pop_block && m_axi.araddr == POP_ADDR) &&
                      (!s_rand || $urandom_range(0, 2) != 0);
      m_axi.rvalid = 1'b0;
      if (s_busy) begin
        if (lat == 0) begin
          m_axi.rvalid = 1'b1;
          if (rd_addr == POP_ADDR && pop_ovr_cnt > 0) m_axi.rdata = {24'h0, pop_ovr};
          else if (q.size() > 0) m_axi.rdata = {24'h0, q[0]};
          else m_axi.rdata = 32'h0;
          m_axi.rresp = (rd_addr == PEEK_ADDR && peek_err_cnt > 0) ? 2'b10 : AXI_RESP_OKAY;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (rr_rand) req_ready = 1'($urandom_range(0, 1));
      if (q.size() == 0 && !s_busy && !m_axi.arvalid && !m_axi.rready && !req_valid) begin
        done = 1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic clear_logs();
    ar_log.delete();
    offer_log.delete();
  endtask

  initial begin : main
    int  n;
    bit  seen;
    rst_n = 1'b0; req_ready = 1'b1; err_clear = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", 32'(m_axi.arvalid), 32'd0);
    chk("rst_rready", 32'(m_axi.rready), 32'd0);
    chk("rst_araddr", 32'(m_axi.araddr), 32'd0);
    chk("rst_req", 32'({req_valid, req_ou_id, req_grid_slot}), 32'd0);
    chk("rst_flags", 32'({err_mismatch, err_resp, err_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero-wait slave, single 0xA3 entry
    clear_logs();
    q.push_back(8'hA3);
    @(negedge clk);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (req_valid) begin n = i; break; end
    end
    chk("t1_latency", 32'(n), 32'd3);
    chk("t1_fields", 32'({req_ou_id, req_grid_slot}), 32'hA3);
    drain("t1");
    chk("t1_ar_count", 32'(ar_log.size()), 32'd2);
    chk("t1_ar0", 32'(ar_log[0]), 32'(PEEK_ADDR));
    chk("t1_ar1", 32'(ar_log[1]), 32'(POP_ADDR));
    chk("t1_offers", 32'(offer_log.size()), 32'd1);
    chk("t1_offer0", 32'(offer_log[0]), 32'hA3);
    chk("t1_flags", 32'({err_mismatch, err_resp, err_timeout}), 32'd0);

    // Loader stalls for 50 cycles
    clear_logs();
    req_ready = 1'b0;
    q.push_back(8'h5C);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_valid) begin seen = 1; break; end
    end
    chk("t3_offer_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t3_hold", 32'({req_valid, req_ou_id, req_grid_slot}), 32'h15C);
    end
    chk("t3_no_pop_yet", 32'(ar_log.size()), 32'd1);
    chk("t3_stable", 32'(stab_viol), 32'd0);
    req_ready = 1'b1;
    drain("t3");
    chk("t3_ar_count", 32'(ar_log.size()), 32'd2);
    chk("t3_offer0", 32'(offer_log[0]), 32'h5C);

    // arready held low past the timeout threshold
    clear_logs();
    s_ar_block = 1;
    q.push_back(8'h77);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_axi.arvalid) begin seen = 1; break; end
    end
    chk("t4_arvalid_up", 32'(seen), 32'd1);
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (i == 1023) chk("t4_timeout_before", 32'(err_timeout), 32'd0);
      if (i == 1024) chk("t4_timeout_at", 32'(err_timeout), 32'd1);
    end
    chk("t4_arvalid_held", 32'({m_axi.arvalid, m_axi.araddr}), 32'({1'b1, PEEK_ADDR}));
    s_ar_block = 0;
    drain("t4");
    chk("t4_offer0", 32'(offer_log[0]), 32'h77);
    chk("t4_sticky", 32'(err_timeout), 32'd1);
    clear_pulse();
    chk("t4_cleared", 32'(err_timeout), 32'd0);

    // Popped word differs from peeked word
    clear_logs();
    pop_ovr = 8'h22; pop_ovr_cnt = 1;
    q.push_back(8'h21);
    drain("t5");
    chk("t5_offer0", 32'(offer_log[0]), 32'h21);
    chk("t5_mismatch", 32'(err_mismatch), 32'd1);
    clear_pulse();
    chk("t5_cleared", 32'(err_mismatch), 32'd0);
    pop_ovr = 8'h30; pop_ovr_cnt = 1;
    q.push_back(8'h31);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (m_axi.rvalid && m_axi.rready && m_axi.araddr == POP_ADDR) begin seen = 1; break; end
    end
    chk("t5_pop_beat_seen", 32'(seen), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t5_set_wins", 32'(err_mismatch), 32'd1);
    drain("t5b");

    // Peek answered with SLVERR
    clear_logs();
    clear_pulse();
    peek_err_cnt = 1;
    q.push_back(8'h4E);
    drain("t6");
    chk("t6_resp", 32'(err_resp), 32'd1);
    chk("t6_ar_count", 32'(ar_log.size()), 32'd3);
    chk("t6_ar_seq", 32'({ar_log[0], ar_log[1], ar_log[2]}), 32'({PEEK_ADDR, PEEK_ADDR, POP_ADDR}));
    chk("t6_offers", 32'(offer_log.size()), 32'd1);
    chk("t6_offer0", 32'(offer_log[0]), 32'h4E);

    // Random slave timing and loader backpressure over a queue of entries
    clear_pulse();
    clear_logs();
    exp_q.delete();
    stab_viol = 0;
    s_rand = 1; rr_rand = 1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      e = 8'($urandom_range(0, 255));
      q.push_back(e);
      exp_q.push_back(e);
    end
    drain("t2");
    s_rand = 0; rr_rand = 0; req_ready = 1'b1;
    chk("t2_offers", 32'(offer_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk("t2_offer", 32'(offer_log[i]), 32'(exp_q[i]));
    chk("t2_ar_count", 32'(ar_log.size()), 32'(2 * exp_q.size()));
    for (int i = 0; i < ar_log.size(); i++)
      chk("t2_ar_seq", 32'(ar_log[i]), (i % 2 == 0) ? 32'(PEEK_ADDR) : 32'(POP_ADDR));
    chk("t2_stable", 32'(stab_viol), 32'd0);
    chk("t2_flags", 32'({err_mismatch, err_resp, err_timeout}), 32'd0);

    // Reset asserted while the pop address phase is stalled
    pop_ovr = 8'h11; pop_ovr_cnt = 1;
    q.push_back(8'h12);
    drain("t7_pre");
    chk("t7_pre_mismatch", 32'(err_mismatch), 32'd1);
    s_pop_block = 1;
    q.push_back(8'h6B);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (m_axi.arvalid && m_axi.araddr == POP_ADDR) begin seen = 1; break; end
    end
    chk("t7_in_pop_ar", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_async_arvalid", 32'(m_axi.arvalid), 32'd0);
    chk("t7_async_req_valid", 32'(req_valid), 32'd0);
    chk("t7_async_flags", 32'({err_mismatch, err_resp, err_timeout}), 32'd0);
    clear_logs();
    s_pop_block = 0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drain("t7");
    chk("t7_ar_count", 32'(ar_log.size()), 32'd2);
    chk("t7_restart_peek", 32'(ar_log[0]), 32'(PEEK_ADDR));
    chk("t7_offer0", 32'(offer_log[0]), 32'h6B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
